// File: rtl/mdu_pkg.sv
// Shared types, encodings and small decode helpers for the iterative
// multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MULTU = 2'b00,
        MULT  = 2'b01,
        DIVU  = 2'b10,
        DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    localparam logic [1:0] OP_MULTU = MULTU;
    localparam logic [1:0] OP_MULT  = MULT;
    localparam logic [1:0] OP_DIVU  = DIVU;
    localparam logic [1:0] OP_DIV   = DIV;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_FIX  = FIX;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_addsub.sv
// (WIDTH+1)-bit adder/subtractor shared by the multiply accumulate and the
// divide trial subtract. cout is the carry on add and the borrow on subtract.
module mdu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] res,
    output logic           cout
);

    logic [WIDTH+1:0] full;

    // Zero-extend one bit so the top bit carries the carry or the borrow.
    always_comb begin
        if (sub) begin
            full = {1'b0, a} - {1'b0, b};
        end else begin
            full = {1'b0, a} + {1'b0, b};
        end
    end

    assign res  = full[WIDTH:0];
    assign cout = full[WIDTH+1];

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers. One product or
// quotient bit per cycle through a shared add/subtract datapath.
// WIDTH must be at least 4 and even.
//
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO writes accepted
//   RUN   | WIDTH shift-add / shift-subtract iterations
//   FIX   | sign correction, HI/LO write-back, done pulse on the next cycle
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    logic               done_q;
    logic               dbz_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     as_a;
    logic [WIDTH:0]     as_b;
    logic               as_sub;
    logic [WIDTH:0]     as_res;
    logic               as_cout;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes for signed ops; unsigned ops pass straight through.
    always_comb begin
        a_neg = op_is_signed(op) && op_a[WIDTH-1];
        b_neg = op_is_signed(op) && op_b[WIDTH-1];
        a_mag = a_neg ? -op_a : op_a;
        b_mag = b_neg ? -op_b : op_b;
    end

    // Shared datapath steering. Multiply adds the multiplicand into the upper
    // half when the current multiplier bit is set; divide trial-subtracts the
    // divisor from the remainder shifted left by one dividend bit.
    always_comb begin
        as_a   = {1'b0, acc_hi};
        as_b   = '0;
        as_sub = 1'b0;
        if (is_div) begin
            as_a   = {acc_hi, acc_lo[WIDTH-1]};
            as_b   = {1'b0, opnd};
            as_sub = 1'b1;
        end else if (acc_lo[0]) begin
            as_b = {1'b0, opnd};
        end
    end

    mdu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (as_sub),
        .res  (as_res),
        .cout (as_cout)
    );

    // Final sign correction applied during FIX.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -acc_lo : acc_lo;
        rem_fix  = neg_r ? -acc_hi : acc_hi;
    end

    // Sequencer, iteration engine and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // start takes priority over same-cycle MT writes
                        state  <= ST_RUN;
                        cnt    <= CNT_LAST;
                        is_div <= op_is_div(op);
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= (op_b == '0);
                        acc_hi <= '0;
                        if (op_is_div(op)) begin
                            acc_lo <= a_mag;
                            opnd   <= b_mag;
                        end else begin
                            acc_lo <= b_mag;
                            opnd   <= a_mag;
                        end
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                ST_RUN: begin
                    if (is_div) begin
                        if (as_cout) begin
                            acc_hi <= as_a[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end else begin
                            acc_hi <= as_res[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        acc_hi <= as_res[WIDTH:1];
                        acc_lo <= {as_res[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b1;
                    if (is_div) begin
                        if (dz) begin
                            dbz_q <= 1'b1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
